// File: rtl/line_track_ctrl.sv
// Line-tracking front end: per-channel sync + debounce of N optical sensors,
// decoded into a registered steering command with a stuck-in-turn timeout.

module line_track_chan #(
   parameter int DEBOUNCE_CNT = 12_500_000,
   parameter int CNT_W        = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic det,
   output logic stable,
   output logic hit
);
   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CNT - 1);

   logic [CNT_W-1:0] cnt;

   assign hit = (det != stable) && (cnt == DB_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (det == stable) begin
         cnt <= '0;
      end else if (hit) begin
         stable <= det;
         cnt    <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

module line_track_ctrl #(
   parameter int NUM_SENSORS  = 4,
   parameter int DEBOUNCE_CNT = 12_500_000,
   parameter int TIMEOUT_CNT  = 50_000_000,
   parameter int ACTIVE_LOW   = 1,
   parameter int CNT_W        = 26
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] sens_in,
   output logic [NUM_SENSORS-1:0] stable,
   output logic                   sens_change,
   output logic [1:0]             dir,
   output logic                   fault,
   output logic [2:0]             state
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FWD    = 3'd1,
      S_VEER_L = 3'd2,
      S_VEER_R = 3'd3,
      S_HALT   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);
   localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT_CNT - 1);

   logic [NUM_SENSORS-1:0] sync1, sync2, det, hit;
   logic [CNT_W-1:0]       tcnt;
   logic                   l_side, r_side;
   state_t                 cur, nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= {NUM_SENSORS{IDLE_LVL}};
         sync2 <= {NUM_SENSORS{IDLE_LVL}};
      end else begin
         sync1 <= sens_in;
         sync2 <= sync1;
      end
   end

   assign det = IDLE_LVL ? ~sync2 : sync2;

   for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
      line_track_chan #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT),
         .CNT_W        (CNT_W)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .det    (det[i]),
         .stable (stable[i]),
         .hit    (hit[i])
      );
   end

   // Odd channels sit on the left of the tape, even channels on the right.
   always_comb begin
      l_side = 1'b0;
      r_side = 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (i % 2 == 1) l_side = l_side | stable[i];
         else            r_side = r_side | stable[i];
      end
   end

   always_comb begin
      nxt = cur;
      if (!enable)                nxt = S_IDLE;
      else if (cur == S_FAULT)    nxt = S_FAULT;
      else if (cur == S_IDLE)     nxt = S_FWD;
      else if (l_side && r_side)  nxt = S_HALT;
      else if (cur == S_HALT)     nxt = S_HALT;   // HALT holds until both sides clear
      else if (l_side)            nxt = S_VEER_L;
      else if (r_side)            nxt = S_VEER_R;
      else                        nxt = S_FWD;
      if (enable && (cur == S_VEER_L || cur == S_VEER_R) && nxt == cur && tcnt == TO_MAX)
         nxt = S_FAULT;
      if (enable && cur == S_HALT && !l_side && !r_side)
         nxt = S_FWD;
   end

   function automatic logic [1:0] dir_of(input state_t s);
      case (s)
         S_FWD:    dir_of = 2'b00;
         S_VEER_L: dir_of = 2'b01;
         S_VEER_R: dir_of = 2'b10;
         default:  dir_of = 2'b11;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         cur         <= S_IDLE;
         dir         <= 2'b11;
         fault       <= 1'b0;
         tcnt        <= '0;
         sens_change <= 1'b0;
      end else begin
         cur         <= nxt;
         dir         <= dir_of(nxt);
         fault       <= (nxt == S_FAULT);
         sens_change <= |hit;
         if (nxt != cur)                           tcnt <= '0;
         else if (cur == S_VEER_L || cur == S_VEER_R) tcnt <= tcnt + 1'b1;
         else                                      tcnt <= '0;
      end
   end

   assign state = cur;
endmodule
